aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Iterative AES block controller: sequences one shared round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey, or the inverse chain with InvMixColumns) over NR rounds per block.
- Holds the 128-bit state register, issues round-key indices to the key store, and selects the MixColumns bypass for the final round.
- Provides valid/ready handshakes on the input and output sides.
- Sits between the block-level wrapper and the combinational round datapath plus key schedule.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256).
- KIW, 4, width of key_idx; must satisfy 2^KIW > NR.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; drops any block in flight.
- in_valid  in  1  input block offered.
- in_ready  out  1  controller can accept a block.
- in_decrypt  in  1  mode for the offered block: 0 = encrypt, 1 = decrypt.
- in_block  in  128  plaintext or ciphertext, byte 0 in [127:120].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_block  out  128  result block.
- out_decrypt  out  1  mode tag of the result.
- busy  out  1  high in ROUND or DONE.
- key_idx  out  KIW  round-key index to the key store.
- round_key  in  128  key store response for key_idx, valid in the same cycle (combinational).
- dp_state  out  128  state register value driven to the round datapath.
- dp_decrypt  out  1  selects the inverse chain.
- dp_last  out  1  final round: datapath bypasses (Inv)MixColumns.
- dp_result  in  128  combinational round result for dp_state, round_key, dp_decrypt and dp_last.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM = IDLE; state = 0; round = 0; mode = 0.
  - out_valid = 0, busy = 0, out_block = 0, out_decrypt = 0, dp_last = 0, key_idx = 0.
  - in_ready = 1, since it is decoded from IDLE.
- FSM states: IDLE, ROUND, DONE. All outputs are decoded from registers, except key_idx in IDLE.
- IDLE:
  - in_ready = 1.
  - key_idx = in_decrypt ? NR : 0 (combinational, so the initial AddRoundKey key is available at the accept edge).
  - Accept on in_valid & in_ready: state <= in_block ^ round_key; mode <= in_decrypt; round <= 1; go to ROUND.
- ROUND:
  - in_ready = 0.
  - key_idx = mode ? NR - round : round.
  - dp_last = (round == NR); dp_decrypt = mode.
  - Each cycle: state <= dp_result.
  - If round == NR, go to DONE; otherwise round <= round + 1.
  - round is KIW bits and never wraps: it stops at NR.
- DONE:
  - out_valid = 1; out_block = state; out_decrypt = mode.
  - On out_ready, go to IDLE.
  - The held values stay stable while out_ready is low (no limit).
- Latency: accept edge at cycle 0; out_valid rises after cycle NR edges, i.e. NR+1 cycles after the accept edge when NR round cycles follow.
  - Per-block occupancy = 1 (IDLE accept) + NR (ROUND) + ≥1 (DONE).
- Back-to-back blocks: in_ready is only high in IDLE, so there is no accept in the DONE→IDLE cycle. The next accept happens the cycle after the handshake.
- flush:
  - Any state goes to IDLE at the next edge; round <= 0; out_valid deasserts.
  - No handshake completes in the flush cycle, even if in_valid & in_ready or out_valid & out_ready are high.
  - flush has priority over every transition.
- in_valid high in ROUND or DONE is ignored (in_ready = 0); the block is not latched.
- in_decrypt and in_block are sampled only at the accept edge. Changes afterwards have no effect on the block in flight.
- Reset mid-operation: immediate return to the reset values; no partial output.

Test Plan:
- FIPS-197 C.1 encrypt: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: out_block = 69c4e0d86a7b0430d8cdb78070b4c55a, out_decrypt = 0.
  - Required: key_idx sequence 0,1,…,10; dp_last high only in the round-10 cycle.
- FIPS-197 C.1 decrypt: ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_block = 00112233445566778899aabbccddeeff.
  - Required: key_idx sequence 10,9,…,0; dp_decrypt = 1 throughout.
- Latency and backpressure: accept at cycle 0.
  - Required: out_valid = 1 first at cycle 11.
  - Hold out_ready = 0 for 5 cycles: out_block is stable, in_ready = 0, and an in_valid pulse is not accepted.
  - After the out_ready handshake: IDLE, in_ready = 1.
- Flush: assert flush in the round-4 cycle.
  - Required: next cycle IDLE, in_ready = 1, no out_valid.
  - A following C.1 encrypt still yields 69c4…c55a.
- Async reset: drop rst_n mid-round (round 6, between clock edges).
  - Required: out_valid, busy and dp_last are 0 immediately; in_ready = 1; state = 0.
  - Release, then run C.1 to the correct result.
- Back-to-back: in_valid held high with two blocks (encrypt C.1, then decrypt C.1) and out_ready tied high.
  - Required: both results correct, in order, with the second accept exactly one cycle after the first output handshake.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Iterative AES block controller: owns the 128-bit state register and steps a
// shared combinational round datapath through NR rounds per block, issuing
// round-key indices and the final-round MixColumns bypass, with valid/ready
// handshakes on both sides.
module aes_round_sequencer #(
  parameter int NR  = 10,
  parameter int KIW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_decrypt,
  input  logic [127:0]   in_block,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_block,
  output logic           out_decrypt,
  output logic           busy,
  output logic [KIW-1:0] key_idx,
  input  logic [127:0]   round_key,
  output logic [127:0]   dp_state,
  output logic           dp_decrypt,
  output logic           dp_last,
  input  logic [127:0]   dp_result
);

  localparam int DATA_W = 128;
  localparam logic [KIW-1:0] NR_K = KIW'(NR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  fsm_t              fsm_q;
  fsm_t              fsm_d;
  logic [DATA_W-1:0] state_q;
  logic [KIW-1:0]    round_q;
  logic              mode_q;
  logic              accept;
  logic              last_round;

  assign last_round = (round_q == NR_K);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state logic and control outputs decoded from the current state;
  // flush overrides every transition, including both handshakes
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    dp_last   = 1'b0;
    key_idx   = '0;
    accept    = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        // Initial AddRoundKey key must be ready at the accept edge
        key_idx  = in_decrypt ? NR_K : '0;
        if (in_valid) begin
          accept = 1'b1;
          fsm_d  = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        key_idx = mode_q ? (NR_K - round_q) : round_q;
        dp_last = last_round;
        if (last_round) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
    if (flush) begin
      fsm_d  = IDLE;
      accept = 1'b0;
    end
  end

  // State register, round counter and mode tag; round saturates at NR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
    end else if (flush) begin
      round_q <= '0;
    end else if (accept) begin
      state_q <= in_block ^ round_key;
      mode_q  <= in_decrypt;
      round_q <= KIW'(1);
    end else if (fsm_q == ROUND) begin
      state_q <= dp_result;
      if (!last_round) begin
        round_q <= round_q + KIW'(1);
      end
    end else if ((fsm_q == DONE) && out_ready) begin
      round_q <= '0;
    end
  end

  assign dp_state    = state_q;
  assign dp_decrypt  = mode_q;
  assign out_block   = state_q;
  assign out_decrypt = mode_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: supplies an AES-128 round datapath and key
// store around the controller, and checks results against FIPS-197 vectors
// and a whole-block AES reference model.
module tb_aes_round_sequencer;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         in_decrypt;
  logic [127:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         out_decrypt;
  logic         busy;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic [127:0] dp_state;
  logic         dp_decrypt;
  logic         dp_last;
  logic [127:0] dp_result;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk       [16];

  aes_round_sequencer #(.NR(10), .KIW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_decrypt (in_decrypt),
    .in_block   (in_block),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .out_decrypt(out_decrypt),
    .busy       (busy),
    .key_idx    (key_idx),
    .round_key  (round_key),
    .dp_state   (dp_state),
    .dp_decrypt (dp_decrypt),
    .dp_last    (dp_last),
    .dp_result  (dp_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end within the time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] getb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? inv_sbox[getb(s, i)] : sbox[getb(s, i)];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!inv) o[127-8*(r+4*c) -: 8] = getb(s, r + 4*((c+r)%4));
        else      o[127-8*(r+4*((c+r)%4)) -: 8] = getb(s, r + 4*c);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = getb(s, 4*c); a1 = getb(s, 4*c+1); a2 = getb(s, 4*c+2); a3 = getb(s, 4*c+3);
      if (!inv) begin
        o[127-8*(4*c)   -: 8] = gmul(a0,8'd2) ^ gmul(a1,8'd3) ^ a2 ^ a3;
        o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1,8'd2) ^ gmul(a2,8'd3) ^ a3;
        o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2,8'd2) ^ gmul(a3,8'd3);
        o[127-8*(4*c+3) -: 8] = gmul(a0,8'd3) ^ a1 ^ a2 ^ gmul(a3,8'd2);
      end else begin
        o[127-8*(4*c)   -: 8] = gmul(a0,8'd14) ^ gmul(a1,8'd11) ^ gmul(a2,8'd13) ^ gmul(a3,8'd9);
        o[127-8*(4*c+1) -: 8] = gmul(a0,8'd9)  ^ gmul(a1,8'd14) ^ gmul(a2,8'd11) ^ gmul(a3,8'd13);
        o[127-8*(4*c+2) -: 8] = gmul(a0,8'd13) ^ gmul(a1,8'd9)  ^ gmul(a2,8'd14) ^ gmul(a3,8'd11);
        o[127-8*(4*c+3) -: 8] = gmul(a0,8'd11) ^ gmul(a1,8'd13) ^ gmul(a2,8'd9)  ^ gmul(a3,8'd14);
      end
    end
    return o;
  endfunction

  // One AES round as the external datapath computes it
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic dec, input logic last);
    logic [127:0] t;
    if (!dec) begin
      t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (!last) t = mix_columns(t, 1'b0);
      t = t ^ k;
    end else begin
      t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
      if (!last) t = mix_columns(t, 1'b1);
    end
    return t;
  endfunction

  // Whole-block AES-128 reference
  function automatic logic [127:0] aes_ref(input logic [127:0] blk, input logic dec);
    logic [127:0] s;
    if (!dec) begin
      s = blk ^ rk[0];
      for (int r = 1; r <= 10; r++) s = round_fn(s, rk[r], 1'b0, r == 10);
    end else begin
      s = blk ^ rk[10];
      for (int r = 1; r <= 10; r++) s = round_fn(s, rk[10-r], 1'b1, r == 10);
    end
    return s;
  endfunction

  task automatic build_sbox();
    logic [7:0] y;
    logic [7:0] v;
    for (int x = 0; x < 256; x++) begin
      y = 8'h01;
      if (x == 0) y = 8'h00;
      else for (int e = 0; e < 254; e++) y = gmul(y, 8'(x));
      v = y ^ rotl8(y,1) ^ rotl8(y,2) ^ rotl8(y,3) ^ rotl8(y,4) ^ 8'h63;
      sbox[x] = v;
      inv_sbox[v] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Key store and round datapath around the controller
  always_comb begin
    round_key = rk[key_idx];
    dp_result = round_fn(dp_state, round_key, dp_decrypt, dp_last);
  end

  // ---------------- checking helpers ----------------
  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one block, follow it round by round, hold the result for `hold`
  // cycles of backpressure, then complete the output handshake.
  task automatic run_block(input logic [127:0] blk, input logic dec,
                           input logic [127:0] exp, input int hold);
    in_valid = 1'b1; in_block = blk; in_decrypt = dec;
    #1;
    check1("idle_in_ready", in_ready, 1'b1);
    check4("idle_key_idx", key_idx, dec ? 4'd10 : 4'd0);
    tick();
    // Perturb inputs after the accept edge; the block in flight must not see it
    in_valid = 1'b0; in_block = ~blk; in_decrypt = ~dec;
    for (int r = 1; r <= 10; r++) begin
      check4("round_key_idx", key_idx, dec ? 4'(10 - r) : 4'(r));
      check1("round_dp_last", dp_last, r == 10);
      check1("round_dp_decrypt", dp_decrypt, dec);
      check1("round_no_out_valid", out_valid, 1'b0);
      tick();
    end
    check1("done_out_valid", out_valid, 1'b1);
    check128("done_out_block", out_block, exp);
    check1("done_out_decrypt", out_decrypt, dec);
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin in_valid = 1'b1; in_block = blk ^ 128'h1; end
      tick();
      in_valid = 1'b0;
      check128("hold_out_block", out_block, exp);
      check1("hold_in_ready", in_ready, 1'b0);
      check1("hold_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check1("post_in_ready", in_ready, 1'b1);
    check1("post_busy", busy, 1'b0);
    check1("post_out_valid", out_valid, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic [127:0] rblk;
    logic [127:0] rkey;
    logic         rdec;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0;
    in_block = '0; out_ready = 1'b0;
    build_sbox();
    expand_key(C1_KEY);

    // Model anchored to FIPS-197 C.1
    check128("model_c1_enc", aes_ref(C1_PT, 1'b0), C1_CT);
    check128("model_c1_dec", aes_ref(C1_CT, 1'b1), C1_PT);

    // Reset values
    repeat (2) tick();
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_dp_last", dp_last, 1'b0);
    check4("rst_key_idx", key_idx, 4'd0);
    check128("rst_out_block", out_block, '0);
    check128("rst_dp_state", dp_state, '0);
    check1("rst_out_decrypt", out_decrypt, 1'b0);
    #2 rst_n = 1'b1;
    tick();

    // FIPS-197 C.1 encrypt and decrypt, with 5 cycles of backpressure on the first
    run_block(C1_PT, 1'b0, C1_CT, 5);
    run_block(C1_CT, 1'b1, C1_PT, 0);

    // flush in IDLE with in_valid high: not accepted
    in_valid = 1'b1; in_block = C1_PT; in_decrypt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check1("flush_idle_busy", busy, 1'b0);
    check1("flush_idle_in_ready", in_ready, 1'b1);

    // flush in the round-4 cycle
    in_valid = 1'b1; in_block = C1_PT; in_decrypt = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check4("flush_round4_key_idx", key_idx, 4'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check1("flush_in_ready", in_ready, 1'b1);
    check1("flush_out_valid", out_valid, 1'b0);
    check1("flush_busy", busy, 1'b0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n++;
      tick();
    end
    check4("flush_no_late_valid", 4'(n), 4'd0);
    run_block(C1_PT, 1'b0, C1_CT, 0);

    // flush in DONE with out_ready high: no output handshake, back to IDLE
    in_valid = 1'b1; in_block = C1_PT; in_decrypt = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check1("flush_done_valid_before", out_valid, 1'b1);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check1("flush_done_out_valid", out_valid, 1'b0);
    check1("flush_done_in_ready", in_ready, 1'b1);

    // Asynchronous reset in the round-6 cycle, between edges
    in_valid = 1'b1; in_block = C1_PT; in_decrypt = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check4("arst_round6_key_idx", key_idx, 4'd6);
    #2 rst_n = 1'b0;
    #1;
    check1("arst_out_valid", out_valid, 1'b0);
    check1("arst_busy", busy, 1'b0);
    check1("arst_dp_last", dp_last, 1'b0);
    check1("arst_in_ready", in_ready, 1'b1);
    check128("arst_state", dp_state, '0);
    #1 rst_n = 1'b1;
    tick();
    run_block(C1_PT, 1'b0, C1_CT, 0);

    // Back-to-back: in_valid held, out_ready tied high
    out_ready = 1'b1;
    in_valid = 1'b1; in_block = C1_PT; in_decrypt = 1'b0;
    tick();
    in_block = C1_CT; in_decrypt = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check4("b2b_first_latency", 4'(n), 4'd10);
    check128("b2b_first_block", out_block, C1_CT);
    check1("b2b_first_mode", out_decrypt, 1'b0);
    tick();
    check1("b2b_gap_in_ready", in_ready, 1'b1);
    check1("b2b_gap_busy", busy, 1'b0);
    check4("b2b_gap_key_idx", key_idx, 4'd10);
    tick();
    in_valid = 1'b0;
    check1("b2b_second_accept", busy, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check4("b2b_second_latency", 4'(n), 4'd10);
    check128("b2b_second_block", out_block, C1_PT);
    check1("b2b_second_mode", out_decrypt, 1'b1);
    tick();
    out_ready = 1'b0;
    check1("b2b_end_in_ready", in_ready, 1'b1);

    // Randomized blocks, keys, modes and backpressure against the reference
    for (int t = 0; t < 10; t++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      rblk = {$urandom, $urandom, $urandom, $urandom};
      rdec = 1'($urandom_range(0, 1));
      expand_key(rkey);
      run_block(rblk, rdec, aes_ref(rblk, rdec), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
